// File: rtl/twobit_26x18_mesh.sv
// twobit_26x18_mesh: a mesh of identical cells over a COLS x ROWS image of
// 2-bit pixels. Each cell flags its pixel as a contour pixel using one of
// three neighbourhood rules. The resulting map is registered once per clock.
module twobit_26x18_mesh #(
  parameter int COLS = 26,
  parameter int ROWS = 18
) (
  input  logic                       clk,
  input  logic                       high,
  input  logic [2*COLS*ROWS-1:0]     inp,
  input  logic [1:0]                 algo,
  output logic [COLS*ROWS-1:0]       contour
);

  localparam int N = COLS * ROWS;

  localparam logic [1:0] ALGO_PIXEL  = 2'b00;
  localparam logic [1:0] ALGO_RDBF   = 2'b01;
  localparam logic [1:0] ALGO_VERTEX = 2'b10;

  // Foreground map padded by a one-pixel background ring. Edge and corner
  // cells then read off-image neighbours as background without special cases.
  logic [ROWS+1:0][COLS+1:0] fg_pad;
  logic [N-1:0]              next_map;
  logic [N-1:0]              contour_d;
  logic [N-1:0]              contour_q;

  genvar gr, gc;

  generate
    for (gr = 0; gr < ROWS + 2; gr++) begin : g_pad_row
      for (gc = 0; gc < COLS + 2; gc++) begin : g_pad_col
        if (gr == 0 || gr == ROWS + 1 || gc == 0 || gc == COLS + 1) begin : g_ring
          assign fg_pad[gr][gc] = 1'b0;
        end else begin : g_img
          // Any non-zero 2-bit value counts as foreground.
          assign fg_pad[gr][gc] = |inp[2*((gr-1)*COLS + (gc-1)) +: 2];
        end
      end
    end
  endgenerate

  generate
    for (gr = 0; gr < ROWS; gr++) begin : g_cell_row
      for (gc = 0; gc < COLS; gc++) begin : g_cell_col
        logic self_fg;
        logic bg_n, bg_s, bg_e, bg_w;
        logic bg_ne, bg_nw, bg_se, bg_sw;
        logic cell_bit;

        // The padded coordinates of this pixel are (gr+1, gc+1).
        assign self_fg = fg_pad[gr+1][gc+1];
        assign bg_n    = ~fg_pad[gr][gc+1];
        assign bg_s    = ~fg_pad[gr+2][gc+1];
        assign bg_w    = ~fg_pad[gr+1][gc];
        assign bg_e    = ~fg_pad[gr+1][gc+2];
        assign bg_nw   = ~fg_pad[gr][gc];
        assign bg_ne   = ~fg_pad[gr][gc+2];
        assign bg_sw   = ~fg_pad[gr+2][gc];
        assign bg_se   = ~fg_pad[gr+2][gc+2];

        // Apply the selected contour rule. A background pixel and the
        // reserved algo code both yield 0.
        always_comb begin
          cell_bit = 1'b0;
          case (algo)
            ALGO_PIXEL:  cell_bit = self_fg & (bg_n | bg_s | bg_e | bg_w);
            ALGO_RDBF:   cell_bit = self_fg & (bg_n | bg_s | bg_e | bg_w |
                                               bg_ne | bg_nw | bg_se | bg_sw);
            ALGO_VERTEX: cell_bit = self_fg & (bg_n | bg_s) & (bg_e | bg_w);
            default:     cell_bit = 1'b0;
          endcase
        end

        assign next_map[gr*COLS + gc] = cell_bit;
      end
    end
  endgenerate

  // The next register value is the full combinational map from this cycle.
  always_comb begin
    contour_d = next_map;
  end

  // The contour register. Reset clears it at once, without waiting for clk.
  always_ff @(posedge clk or negedge high) begin
    if (!high) begin
      contour_q <= '0;
    end else begin
      contour_q <= contour_d;
    end
  end

  assign contour = contour_q;

endmodule

// File: tb/tb_twobit_26x18_mesh.sv
// Directed testbench for twobit_26x18_mesh. Expected contour maps are
// hand-derived bit sets for each test image.
module tb_twobit_26x18_mesh;

  localparam int COLS = 26;
  localparam int ROWS = 18;
  localparam int N    = COLS * ROWS;

  logic           clk;
  logic           high;
  logic [2*N-1:0] inp;
  logic [1:0]     algo;
  logic [N-1:0]   contour;

  int n_tests;
  int n_fail;

  logic [N-1:0] exp_border;
  logic [N-1:0] exp_corner;
  logic [N-1:0] exp_single;
  logic [N-1:0] exp_notch_pf;
  logic [N-1:0] exp_notch_rdbf;
  logic [N-1:0] exp_notch_vf;
  logic [N-1:0] zero_map;

  twobit_26x18_mesh #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk     (clk),
    .high    (high),
    .inp     (inp),
    .algo    (algo),
    .contour (contour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pidx(input int r, input int c);
    return r * COLS + c;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int r, input int c, input logic [1:0] v);
    inp[2*pidx(r, c) +: 2] = v;
  endtask

  task automatic load_notch();
    inp = '0;
    for (int r = 2; r <= 4; r++)
      for (int c = 2; c <= 4; c++)
        set_px(r, c, 2'b10);
    set_px(2, 2, 2'b00);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    zero_map = '0;

    // Expected maps derived by hand from the image geometry.
    exp_border = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1)
          exp_border[pidx(r, c)] = 1'b1;
    exp_corner = '0;
    exp_corner[0]   = 1'b1;
    exp_corner[25]  = 1'b1;
    exp_corner[442] = 1'b1;
    exp_corner[467] = 1'b1;
    exp_single = '0;
    exp_single[135] = 1'b1;
    exp_notch_pf = '0;
    exp_notch_pf[55]  = 1'b1;
    exp_notch_pf[56]  = 1'b1;
    exp_notch_pf[80]  = 1'b1;
    exp_notch_pf[82]  = 1'b1;
    exp_notch_pf[106] = 1'b1;
    exp_notch_pf[107] = 1'b1;
    exp_notch_pf[108] = 1'b1;
    exp_notch_rdbf = exp_notch_pf;
    exp_notch_rdbf[81] = 1'b1;
    exp_notch_vf = '0;
    exp_notch_vf[55]  = 1'b1;
    exp_notch_vf[56]  = 1'b1;
    exp_notch_vf[80]  = 1'b1;
    exp_notch_vf[106] = 1'b1;
    exp_notch_vf[108] = 1'b1;

    // Reset asserted from time 0 with a busy image.
    high = 1'b0;
    inp  = {N{2'b11}};
    algo = 2'b00;
    #1;
    chk("reset_async_t0", contour, zero_map);
    tick();
    tick();
    chk("reset_held", contour, zero_map);

    // Release with a blank image.
    inp  = '0;
    high = 1'b1;
    #1;
    chk("release_no_edge", contour, zero_map);
    tick();
    chk("blank_pf", contour, zero_map);
    algo = 2'b01;
    tick();
    chk("blank_rdbf", contour, zero_map);

    // Full foreground image.
    inp  = {N{2'b11}};
    algo = 2'b00;
    tick();
    chk("full_pf", contour, exp_border);
    algo = 2'b01;
    tick();
    chk("full_rdbf", contour, exp_border);
    algo = 2'b10;
    tick();
    chk("full_vf", contour, exp_corner);
    algo = 2'b11;
    tick();
    chk("full_reserved", contour, zero_map);

    // Single isolated pixel at (5,5).
    inp = '0;
    set_px(5, 5, 2'b01);
    algo = 2'b00;
    tick();
    chk("single_pf", contour, exp_single);
    algo = 2'b01;
    tick();
    chk("single_rdbf", contour, exp_single);
    algo = 2'b10;
    tick();
    chk("single_vf", contour, exp_single);
    algo = 2'b11;
    tick();
    chk("single_reserved", contour, zero_map);

    // Notched 3x3 block, algo stepping on consecutive edges.
    load_notch();
    algo = 2'b00;
    tick();
    chk("notch_pf", contour, exp_notch_pf);
    algo = 2'b01;
    tick();
    chk("notch_rdbf", contour, exp_notch_rdbf);
    algo = 2'b10;
    tick();
    chk("notch_vf", contour, exp_notch_vf);
    algo = 2'b00;
    tick();
    chk("notch_cycle_pf", contour, exp_notch_pf);

    // Only the algo value present at the edge matters.
    algo = 2'b11;
    #2;
    algo = 2'b01;
    tick();
    chk("algo_glitch_rdbf", contour, exp_notch_rdbf);

    // Mid-operation reset pulse between edges.
    #2;
    high = 1'b0;
    #1;
    chk("midreset_async", contour, zero_map);
    tick();
    tick();
    chk("midreset_held", contour, zero_map);
    high = 1'b1;
    #1;
    chk("midreset_release_no_edge", contour, zero_map);
    tick();
    chk("midreset_resume", contour, exp_notch_rdbf);

    // Pixel values 01/10/11 all count as foreground on the full image.
    inp  = {N{2'b10}};
    algo = 2'b00;
    tick();
    chk("full10_pf", contour, exp_border);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/twobit_26x18_mesh.md
Name: twobit_26x18_mesh

Overview:
Combinational cell mesh over a 26-column x 18-row image of 2-bit pixels (468 pixels), with a registered 1-bit-per-pixel contour map. Each cell classifies its pixel as foreground/background and decides contour membership from its own neighbourhood using one of three selectable rules: pixel following, RDBF or vertex following. The block is the image-processing core; `inp` comes from a frame/pixel loader and `contour` goes to downstream readout.

Parameters:
COLS, 26, image width in pixels (columns).
ROWS, 18, image height in pixels (rows); pixel count N = COLS*ROWS = 468.

Ports:
clk  input  1  rising-edge clock.
high  input  1  reset; asynchronous, active-low (0 = reset asserted).
inp  input  2*N (936)  packed image; pixel p occupies inp[2p+1:2p].
algo  input  2  algorithm select: 00 pixel following, 01 RDBF, 10 vertex following, 11 reserved.
contour  output  N (468)  registered contour map; bit p = pixel p is on the contour.

Behaviour:
- Pixel indexing: p = r*COLS + c, with row r in 0..ROWS-1 and column c in 0..COLS-1. Pixel 0 is the top-left pixel, at the LSBs. North is r-1, south r+1, west c-1, east c+1.
- Foreground: F(p) = 1 iff the 2-bit value is not 2'b00. Values 01, 10 and 11 are all foreground.
- Off-image neighbours (outside rows 0..ROWS-1 or cols 0..COLS-1) count as background.
- Each cell computes its next contour bit combinationally. A background pixel always gives 0.
- algo 00, pixel following: 1 iff F(p) and at least one 4-neighbour (N/S/E/W) is background.
- algo 01, RDBF: 1 iff F(p) and at least one 8-neighbour (4-neighbours plus the diagonals) is background.
- algo 10, vertex following: 1 iff F(p) and at least one of N/S is background and at least one of E/W is background.
- algo 11: all bits 0.
- Register: on every rising clk while high=1, contour <= next map computed from the current inp and algo.
  - Latency is exactly 1 clock from inp/algo to contour.
  - No enable; the output updates every cycle.
- Reset: high=0 clears contour to all zeros immediately, without waiting for clk, and holds it there.
  - Applies at any time, including mid-stream.
  - The first capture is the first rising clk after high returns to 1.
- If algo or inp changes between edges, only the values present at the edge matter. No internal state other than the contour register.
- Cells are identical; build them with generate loops. Edge/corner cells differ only by tying off-image neighbours to background.

Test Plan:
- Reset and blank image: high=0 with any inp gives contour=0 asynchronously. Release high, inp=0, any algo, one clk gives contour=0.
- Full image: all pixels 2'b11, algo=00, one clk gives the 84 border bits set (rows 0 and 17, cols 0 and 25) and all interior bits 0. algo=01 gives the same 84 bits. algo=10 gives only the 4 corners: bits 0, 25, 442 and 467.
- Single pixel: only pixel (5,5) = 2'b01, so p = 135. Each of algo 00, 01 and 10 gives contour bit 135 only. algo=11 gives 0.
- Notched block: foreground 3x3 at rows 2-4, cols 2-4, except (2,2) background.
  - algo=00: bits for (2,3), (2,4), (3,2), (3,4), (4,2), (4,3), (4,4) set; centre (3,3) = bit 81 clear.
  - algo=01: the same 7 bits plus bit 81 set (its diagonal neighbour (2,2) is background).
  - algo=10: bits for (2,4), (4,2), (4,4) set, plus (2,3) and (3,2). (2,3) has N background and W background (2,2); (3,2) has W background and N background (2,2).
- Algorithm cycling: fixed test image, algo stepping 00→01→10→00 on consecutive edges. Each contour value matches the rule of the algo sampled one edge earlier, with no stale mixing.
- Mid-operation reset: pulse high low between edges while contour is non-zero. contour goes to 0 at once, stays 0 while high=0, and resumes the correct map one clk after release.
